// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - golden-sum checker for 32-bit adders; optional FIRST_FAIL_CAPTURE_EN
module adder_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic             res_sum_err,
  output logic             res_cout_err,
  output logic             res_of,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             done
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_cin,
  output logic [WIDTH-1:0] ff_sum,
  output logic             ff_cout
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] nv_q;
  logic [CNT_W-1:0] acc_q;
  logic             adv;
  logic             in_xfer;
  logic             res_xfer;
  logic             last_xfer;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
  logic             s1_cin, s1_cout;
  logic [WIDTH:0]   golden;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_cin, r_cout;
`endif

  // Global stall: both stages move together only when the verdict slot frees up.
  // start blocks intake so no vector is handshaken into a pipeline about to be flushed.
  assign adv       = !res_valid || res_ready;
  assign in_ready  = (state_q == RUN) && (acc_q < nv_q) && adv && !start;
  assign in_xfer   = in_valid && in_ready;
  assign res_xfer  = res_valid && res_ready && !start;
  assign last_xfer = res_xfer && ((vec_count + CNT_ONE) == nv_q);
  assign done      = (state_q == DONE);

  assign golden = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};

  // Run-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start always wins, the last delivered verdict ends the run.
  always_comb begin
    state_d = state_q;
    if (start)
      state_d = (num_vectors == '0) ? DONE : RUN;
    else if ((state_q == RUN) && last_xfer)
      state_d = DONE;
  end

  // Stage 1: capture the incoming vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sum   <= '0;
      s1_cout  <= 1'b0;
    end else if (start) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_cin  <= cin;
        s1_sum  <= dut_sum;
        s1_cout <= dut_cout;
      end
    end
  end

  // Stage 2: compare against the golden sum and register the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_pass     <= 1'b0;
      res_sum_err  <= 1'b0;
      res_cout_err <= 1'b0;
      res_of       <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
`endif
    end else if (start) begin
      res_valid    <= 1'b0;
      res_pass     <= 1'b0;
      res_sum_err  <= 1'b0;
      res_cout_err <= 1'b0;
      res_of       <= 1'b0;
    end else if (adv) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_sum_err  <= (s1_sum != golden[WIDTH-1:0]);
        res_cout_err <= (s1_cout != golden[WIDTH]);
        res_pass     <= (s1_sum == golden[WIDTH-1:0]) && (s1_cout == golden[WIDTH]);
        res_of       <= (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                        (golden[WIDTH-1] != s1_a[WIDTH-1]);
`ifdef FIRST_FAIL_CAPTURE_EN
        r_a    <= s1_a;
        r_b    <= s1_b;
        r_cin  <= s1_cin;
        r_sum  <= s1_sum;
        r_cout <= s1_cout;
`endif
      end
    end
  end

  // Run bookkeeping: intake count, delivered verdicts, saturating failure count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_q       <= '0;
      acc_q      <= '0;
      vec_count  <= '0;
      fail_count <= '0;
    end else if (start) begin
      nv_q       <= num_vectors;
      acc_q      <= '0;
      vec_count  <= '0;
      fail_count <= '0;
    end else begin
      if (in_xfer)
        acc_q <= acc_q + CNT_ONE;
      if (res_xfer) begin
        vec_count <= vec_count + CNT_ONE;
        if (!res_pass && (fail_count != '1))
          fail_count <= fail_count + CNT_ONE;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // Latch the inputs of the first failing verdict delivered in this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_cin   <= 1'b0;
      ff_sum   <= '0;
      ff_cout  <= 1'b0;
    end else if (start) begin
      ff_valid <= 1'b0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_cin   <= 1'b0;
      ff_sum   <= '0;
      ff_cout  <= 1'b0;
    end else if (res_xfer && !res_pass && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_a     <= r_a;
      ff_b     <= r_b;
      ff_cin   <= r_cin;
      ff_sum   <= r_sum;
      ff_cout  <= r_cout;
    end
  end
`endif

endmodule
